// File: rtl/grad_dir_pkg.sv
// Shared constants and helpers for the gradient-direction scheduler.
package grad_dir_pkg;

  // Same-sign sector codes: |y|/|x| compared against tan 0, 22.5, 45, 67.5.
  localparam logic [3:0] SECTOR_EQ0    = 4'd0;
  localparam logic [3:0] SECTOR_LT22   = 4'd1;
  localparam logic [3:0] SECTOR_EQ22   = 4'd2;
  localparam logic [3:0] SECTOR_LT45   = 4'd3;
  localparam logic [3:0] SECTOR_EQ45   = 4'd4;
  localparam logic [3:0] SECTOR_LT67   = 4'd5;
  localparam logic [3:0] SECTOR_EQ67   = 4'd6;
  localparam logic [3:0] SECTOR_GT67   = 4'd7;
  // Opposite-sign sector codes mirror the same-sign ones (15 - code).
  localparam logic [3:0] SECTOR_M_GT67 = 4'd8;
  localparam logic [3:0] SECTOR_M_EQ67 = 4'd9;
  localparam logic [3:0] SECTOR_M_LT67 = 4'd10;
  localparam logic [3:0] SECTOR_M_EQ45 = 4'd11;
  localparam logic [3:0] SECTOR_M_LT45 = 4'd12;
  localparam logic [3:0] SECTOR_M_EQ22 = 4'd13;
  localparam logic [3:0] SECTOR_M_LT22 = 4'd14;
  localparam logic [3:0] SECTOR_M_EQ0  = 4'd15;

  // NMS direction bins.
  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  // tan(22.5), tan(45), tan(67.5) in Q.7.
  localparam int TAN_22_Q7 = 53;
  localparam int TAN_45_Q7 = 128;
  localparam int TAN_67_Q7 = 309;

  // Fold the 16 sector codes into the four NMS bins.
  function automatic logic [1:0] sector_to_dir(input logic [3:0] code);
    logic [1:0] dir;
    if (code <= SECTOR_LT22 || code >= SECTOR_M_LT22) begin
      dir = DIR_0;
    end else if (code <= SECTOR_LT67) begin
      dir = DIR_45;
    end else if (code <= SECTOR_M_EQ67) begin
      dir = DIR_90;
    end else begin
      dir = DIR_135;
    end
    return dir;
  endfunction

endpackage

// File: rtl/grad_sector_classify.sv
// Combinational classifier: signed 14-bit (x, y) gradient to 4-bit sector code.
module grad_sector_classify
  import grad_dir_pkg::*;
(
  input  logic [13:0] i_x,
  input  logic [13:0] i_y,
  output logic [3:0]  o_code
);

  logic [13:0] w_ax;
  logic [13:0] w_ay;
  logic [23:0] w_lhs;
  logic [23:0] w_t22;
  logic [23:0] w_t45;
  logic [23:0] w_t67;
  logic        w_opp;
  logic [3:0]  w_pos;

  // Magnitudes; -8192 wraps and is not a legal operand.
  assign w_ax  = i_x[13] ? (~i_x + 14'd1) : i_x;
  assign w_ay  = i_y[13] ? (~i_y + 14'd1) : i_y;
  assign w_lhs = {3'b000, w_ay, 7'b0000000};
  assign w_t22 = 24'(w_ax) * 24'(TAN_22_Q7);
  assign w_t45 = 24'(w_ax) * 24'(TAN_45_Q7);
  assign w_t67 = 24'(w_ax) * 24'(TAN_67_Q7);
  assign w_opp = i_x[13] ^ i_y[13];

  // Locate |y|*128 among the tangent thresholds scaled by |x|.
  always_comb begin
    w_pos = SECTOR_GT67;
    if (w_lhs == 24'd0) begin
      w_pos = SECTOR_EQ0;
    end else if (w_lhs < w_t22) begin
      w_pos = SECTOR_LT22;
    end else if (w_lhs == w_t22) begin
      w_pos = SECTOR_EQ22;
    end else if (w_lhs < w_t45) begin
      w_pos = SECTOR_LT45;
    end else if (w_lhs == w_t45) begin
      w_pos = SECTOR_EQ45;
    end else if (w_lhs < w_t67) begin
      w_pos = SECTOR_LT67;
    end else if (w_lhs == w_t67) begin
      w_pos = SECTOR_EQ67;
    end
  end

  // Opposite signs select the mirrored code.
  always_comb begin
    o_code = w_pos;
    if (w_opp) begin
      case (w_pos)
        SECTOR_EQ0:  o_code = SECTOR_M_EQ0;
        SECTOR_LT22: o_code = SECTOR_M_LT22;
        SECTOR_EQ22: o_code = SECTOR_M_EQ22;
        SECTOR_LT45: o_code = SECTOR_M_LT45;
        SECTOR_EQ45: o_code = SECTOR_M_EQ45;
        SECTOR_LT67: o_code = SECTOR_M_LT67;
        SECTOR_EQ67: o_code = SECTOR_M_EQ67;
        default:     o_code = SECTOR_M_GT67;
      endcase
    end
  end

endmodule

// File: rtl/grad_dir_scheduler.sv
// Round-robin scheduler sharing one sector classifier among N_REQ requesters,
// with a registered operand stage and a tagged result FIFO.
// Handshakes: a request transfers on an edge where i_req_valid[r] and
// o_req_ready[r] are both high; a result transfers on an edge where
// o_res_valid and i_res_ready are both high. Head outputs stay stable
// while o_res_valid is high and i_res_ready is low.
module grad_dir_scheduler
  import grad_dir_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [14*N_REQ-1:0]  i_req_x,
  input  logic [14*N_REQ-1:0]  i_req_y,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [ID_W-1:0]      o_res_id,
  output logic [3:0]           o_res_code,
  output logic [1:0]           o_res_dir,
  output logic                 o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [ID_W-1:0] r_rr_ptr;
  logic            r_op_valid;
  logic [13:0]     r_op_x;
  logic [13:0]     r_op_y;
  logic [ID_W-1:0] r_op_id;

  logic [ID_W-1:0] r_mem_id   [FIFO_DEPTH];
  logic [3:0]      r_mem_code [FIFO_DEPTH];
  logic [1:0]      r_mem_dir  [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic             w_credit;
  logic [N_REQ-1:0] w_grant;
  logic             w_grant_any;
  logic [ID_W-1:0]  w_grant_id;
  logic [ID_W-1:0]  w_rr_next;
  logic [13:0]      w_sel_x;
  logic [13:0]      w_sel_y;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_code;
  logic [1:0]       w_dir;
  int               w_idx;

  // A grant is allowed only while every in-flight result has a FIFO slot.
  assign w_credit = (r_count + CW'(r_op_valid)) < CW'(FIFO_DEPTH);

  // Round-robin search from r_rr_ptr upward with wrap.
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_idx       = 0;
    if (w_credit) begin
      for (int i = 0; i < N_REQ; i++) begin
        w_idx = int'(r_rr_ptr) + i;
        if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
        if (!w_grant_any && i_req_valid[w_idx]) begin
          w_grant_any    = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_grant_id     = ID_W'(w_idx);
          w_sel_x        = i_req_x[w_idx*14 +: 14];
          w_sel_y        = i_req_y[w_idx*14 +: 14];
        end
      end
    end
  end

  assign w_rr_next   = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
  assign o_req_ready = w_grant;

  grad_sector_classify u_classify (
    .i_x    (r_op_x),
    .i_y    (r_op_y),
    .o_code (w_code)
  );

  assign w_dir  = sector_to_dir(w_code);
  assign w_push = r_op_valid;
  assign w_pop  = (r_count != '0) && i_res_ready;

  // Arbiter pointer and operand stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr   <= '0;
      r_op_valid <= 1'b0;
    end else begin
      r_op_valid <= w_grant_any;
      if (w_grant_any) begin
        r_rr_ptr <= w_rr_next;
        r_op_x   <= w_sel_x;
        r_op_y   <= w_sel_y;
        r_op_id  <= w_grant_id;
      end
    end
  end

  // Result FIFO: simultaneous push and pop are both honoured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_id[r_wr_ptr]   <= r_op_id;
        r_mem_code[r_wr_ptr] <= w_code;
        r_mem_dir[r_wr_ptr]  <= w_dir;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head outputs read as zero while the FIFO is empty.
  assign o_res_valid = (r_count != '0);
  assign o_res_id    = o_res_valid ? r_mem_id[r_rd_ptr]   : '0;
  assign o_res_code  = o_res_valid ? r_mem_code[r_rd_ptr] : '0;
  assign o_res_dir   = o_res_valid ? r_mem_dir[r_rd_ptr]  : '0;
  assign o_busy      = r_op_valid | o_res_valid;

endmodule

// File: tb/tb_grad_dir_scheduler.sv
// Bench for grad_dir_scheduler: queued expectations from a reference model,
// checked by an independent output monitor.
module tb_grad_dir_scheduler;

  localparam int N_REQ      = 2;
  localparam int ID_W       = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int RW         = ID_W + 6;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ-1:0]    o_req_ready;
  logic [14*N_REQ-1:0] i_req_x;
  logic [14*N_REQ-1:0] i_req_y;
  logic                o_res_valid;
  logic                i_res_ready;
  logic [ID_W-1:0]     o_res_id;
  logic [3:0]          o_res_code;
  logic [1:0]          o_res_dir;
  logic                o_busy;

  logic [RW-1:0] exp_q[$];
  int            vis_q[$];
  int            cycle_n   = 0;
  int            model_ptr = 0;
  int            n_checks  = 0;
  int            n_errors  = 0;
  bit            mon_en    = 1'b0;
  bit            cur_push  = 1'b0;

  grad_dir_scheduler #(
    .N_REQ      (N_REQ),
    .ID_W       (ID_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_x     (i_req_x),
    .i_req_y     (i_req_y),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_id    (o_res_id),
    .o_res_code  (o_res_code),
    .o_res_dir   (o_res_dir),
    .o_busy      (o_busy)
  );

  // Clock and watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle_n);
    end
  endtask

  // Reference model: count thresholds strictly below |y|*128, note equality.
  function automatic int ref_code(input int x, input int y);
    int t[4];
    int ax, ay, lhs, n_gt, code;
    bit eq;
    t[0] = 0; t[1] = 53; t[2] = 128; t[3] = 309;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    lhs = ay * 128;
    n_gt = 0;
    eq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (lhs > ax * t[k]) n_gt++;
      if (lhs == ax * t[k]) eq = 1'b1;
    end
    code = eq ? 2 * n_gt : 2 * n_gt - 1;
    if ((x < 0) != (y < 0)) code = 15 - code;
    return code;
  endfunction

  function automatic int ref_dir(input int code);
    return ((code + 2) / 4) % 4;
  endfunction

  // Driver: one cycle of stimulus, arbitration model check, expectation push.
  task automatic do_cycle(input logic [N_REQ-1:0] v, input logic [14*N_REQ-1:0] xs,
                          input logic [14*N_REQ-1:0] ys, input logic rr,
                          input int fcode, input int fdir);
    logic [N_REQ-1:0] exp_ready;
    int g, gx, gy, code, dir;
    logic [13:0] fx, fy;
    @(negedge i_clk);
    i_req_valid = v;
    i_req_x     = xs;
    i_req_y     = ys;
    i_res_ready = rr;
    cycle_n++;
    cur_push = 1'b0;
    #1;
    exp_ready = '0;
    g = -1;
    if (exp_q.size() < FIFO_DEPTH) begin
      for (int i = 0; i < N_REQ; i++) begin
        int idx;
        idx = (model_ptr + i) % N_REQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(o_req_ready), 32'(exp_ready));
    if (g >= 0) begin
      fx = xs[14*g +: 14];
      fy = ys[14*g +: 14];
      gx = int'($signed(fx));
      gy = int'($signed(fy));
      code = (fcode >= 0) ? fcode : ref_code(gx, gy);
      dir  = (fdir >= 0) ? fdir : ref_dir(code);
      exp_q.push_back({ID_W'(g), 4'(code), 2'(dir)});
      vis_q.push_back(cycle_n + 2);
      cur_push = 1'b1;
      model_ptr = (g + 1) % N_REQ;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle('0, '0, '0, 1'b1, -1, -1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge i_clk);
    i_rst       = 1'b1;
    i_req_valid = '0;
    i_res_ready = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_req_ready", 32'(o_req_ready), 32'd0);
    check("rst_res_valid", 32'(o_res_valid), 32'd0);
    check("rst_res_id", 32'(o_res_id), 32'd0);
    check("rst_res_code", 32'(o_res_code), 32'd0);
    check("rst_res_dir", 32'(o_res_dir), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    exp_q.delete();
    vis_q.delete();
    model_ptr = 0;
    mon_en = 1'b1;
  endtask

  // Random gradient pair, excluding -8192, biased toward threshold equalities.
  task automatic gen_pair(output logic [13:0] x, output logic [13:0] y);
    int mode, m, sx, sy, xi, yi;
    mode = $urandom_range(0, 4);
    sx = ($urandom_range(0, 1) == 1) ? -1 : 1;
    sy = ($urandom_range(0, 1) == 1) ? -1 : 1;
    case (mode)
      0: begin xi = $urandom_range(0, 16382) - 8191; yi = $urandom_range(0, 16382) - 8191; end
      1: begin xi = $urandom_range(0, 400) - 200; yi = $urandom_range(0, 400) - 200; end
      2: begin m = $urandom_range(1, 60); xi = sx * 128 * m; yi = sy * 53 * m; end
      3: begin m = $urandom_range(1, 26); xi = sx * 128 * m; yi = sy * 309 * m; end
      default: begin m = $urandom_range(0, 8000); xi = sx * m; yi = sy * ($urandom_range(0, 1) == 1 ? m : 0); end
    endcase
    x = 14'(xi);
    y = 14'(yi);
  endtask

  task automatic rand_cycle(input logic [N_REQ-1:0] v, input logic rr);
    logic [14*N_REQ-1:0] xs, ys;
    logic [13:0] x, y;
    for (int r = 0; r < N_REQ; r++) begin
      gen_pair(x, y);
      xs[14*r +: 14] = x;
      ys[14*r +: 14] = y;
    end
    do_cycle(v, xs, ys, rr, -1, -1);
  endtask

  // Monitor: checks head validity, busy, and head contents every cycle.
  initial begin
    logic exp_valid, exp_busy;
    forever begin
      @(negedge i_clk);
      #2;
      if (mon_en) begin
        exp_valid = (exp_q.size() > 0) && (vis_q[0] <= cycle_n);
        exp_busy  = (exp_q.size() - int'(cur_push)) > 0;
        check("res_valid", 32'(o_res_valid), 32'(exp_valid));
        check("busy", 32'(o_busy), 32'(exp_busy));
        if (o_res_valid && exp_valid) begin
          check("res_head", 32'({o_res_id, o_res_code, o_res_dir}), 32'(exp_q[0]));
          if (i_res_ready) begin
            void'(exp_q.pop_front());
            void'(vis_q.pop_front());
          end
        end
      end
    end
  end

  // Directed sector vectors with hand-derived codes and bins.
  int dx[9] = '{100, 100, 100, 100, 0, 0, -100, 100, -100};
  int dy[9] = '{0, 41, 42, 100, 0, 50, 100, -41, -100};
  int dc[9] = '{0, 1, 3, 4, 0, 7, 11, 14, 4};
  int dd[9] = '{0, 0, 1, 1, 0, 2, 3, 0, 1};

  initial begin
    logic [14*N_REQ-1:0] xs, ys;
    i_rst       = 1'b1;
    i_req_valid = '0;
    i_req_x     = '0;
    i_req_y     = '0;
    i_res_ready = 1'b0;
    do_reset();
    idle(10);

    for (int k = 0; k < 9; k++) begin
      xs = '0;
      ys = '0;
      xs[13:0] = 14'(dx[k]);
      ys[13:0] = 14'(dy[k]);
      model_ptr = model_ptr;
      do_cycle(2'b01, xs, ys, 1'b1, dc[k], dd[k]);
      idle(3);
    end

    for (int k = 0; k < 8; k++) rand_cycle(2'b11, 1'b1);
    idle(4);

    for (int k = 0; k < 8; k++) rand_cycle(2'b11, 1'b0);
    for (int k = 0; k < 10; k++) rand_cycle(2'b11, 1'b1);
    idle(4);

    for (int k = 0; k < 400; k++) begin
      rand_cycle(N_REQ'($urandom_range(0, (1 << N_REQ) - 1)), $urandom_range(0, 3) != 0);
    end

    for (int k = 0; k < 6; k++) rand_cycle(2'b11, 1'b0);
    do_reset();
    idle(10);

    for (int k = 0; k < 100; k++) begin
      rand_cycle(N_REQ'($urandom_range(0, (1 << N_REQ) - 1)), $urandom_range(0, 1) == 1);
    end

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) idle(1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
